// File: rtl/adc_pkg.sv
// Shared definitions for the ADC sample averager: widths, defaults, FSM encoding.
package adc_pkg;

    localparam int unsigned ADC_DATA_W = 16;
    localparam int unsigned ADC_LOG2_N = 3;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } avg_state_e;

    // Sum of 2^log2_n samples of data_w bits never exceeds data_w+log2_n bits.
    function automatic int unsigned acc_width(input int unsigned data_w, input int unsigned log2_n);
        return data_w + log2_n;
    endfunction

endpackage

// File: rtl/adc_avg_accum.sv
// Block accumulator: sums 2^LOG2_N samples, produces a round-half-up mean and a
// one-cycle completion pulse in the same cycle the last sample is presented.
module adc_avg_accum
    import adc_pkg::*;
#(
    parameter int unsigned DATA_W = ADC_DATA_W,
    parameter int unsigned LOG2_N = ADC_LOG2_N
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_enable,
    input  logic              i_sample_valid,
    input  logic [DATA_W-1:0] i_sample_data,
    output logic [DATA_W-1:0] o_result_c,
    output logic              o_done_c,
    output logic [LOG2_N:0]   o_cnt
);

    localparam int unsigned ACC_W = acc_width(DATA_W, LOG2_N);
    localparam int unsigned CNT_W = LOG2_N + 1;
    localparam int unsigned N     = 1 << LOG2_N;

    logic [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic [ACC_W-1:0] w_sum;
    logic             w_last;

    assign w_sum    = r_acc + ACC_W'(i_sample_data);
    assign w_last   = (r_cnt == CNT_W'(N - 1));
    assign o_done_c = i_enable & i_sample_valid & w_last;
    assign o_cnt    = r_cnt;

    // Rounding term N/2 cannot carry out of ACC_W: max sum + N/2 < N * 2^DATA_W.
    generate
        if (LOG2_N == 0) begin : g_passthru
            assign o_result_c = i_sample_data;
        end else begin : g_round
            logic [ACC_W-1:0] w_round;
            assign w_round    = w_sum + ACC_W'(N / 2);
            assign o_result_c = DATA_W'(w_round >> LOG2_N);
        end
    endgenerate

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (!i_enable) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (i_sample_valid) begin
            if (w_last) begin
                r_acc <= '0;
                r_cnt <= '0;
            end else begin
                r_acc <= w_sum;
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/adc_sample_averager.sv
// ADC block averager: accumulates 2^LOG2_N samples and presents the rounded mean
// on a valid/ready port; results completing while the port is stalled are dropped.
module adc_sample_averager
    import adc_pkg::*;
#(
    parameter int unsigned DATA_W = ADC_DATA_W,
    parameter int unsigned LOG2_N = ADC_LOG2_N
) (
    input  logic              i_sclk,
    input  logic              i_rst_n,
    input  logic              i_enable,
    input  logic [DATA_W-1:0] i_sample_data,
    input  logic              i_sample_valid,
    output logic [DATA_W-1:0] o_avg_data,
    output logic              o_avg_valid,
    input  logic              i_avg_ready,
    output logic              o_overrun,
    input  logic              i_overrun_clr,
    output logic [LOG2_N:0]   o_sample_cnt
);

    avg_state_e        r_state;
    avg_state_e        w_state_nxt;
    logic [DATA_W-1:0] w_result;
    logic              w_done;
    logic              w_load;
    logic              w_drop;
    logic [DATA_W-1:0] r_avg_data;
    logic              r_overrun;

    adc_avg_accum #(
        .DATA_W (DATA_W),
        .LOG2_N (LOG2_N)
    ) u_accum (
        .i_clk          (i_sclk),
        .i_rst_n        (i_rst_n),
        .i_enable       (i_enable),
        .i_sample_valid (i_sample_valid),
        .i_sample_data  (i_sample_data),
        .o_result_c     (w_result),
        .o_done_c       (w_done),
        .o_cnt          (o_sample_cnt)
    );

    always_ff @(posedge i_sclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A completion always leaves the slot full, either loaded or still holding.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: if (w_done)                 w_state_nxt = ST_FULL;
            ST_FULL:  if (i_avg_ready && !w_done) w_state_nxt = ST_EMPTY;
        endcase
    end

    always_comb begin
        w_load = 1'b0;
        w_drop = 1'b0;
        if (w_done) begin
            if ((r_state == ST_EMPTY) || i_avg_ready) begin
                w_load = 1'b1;
            end else begin
                w_drop = 1'b1;
            end
        end
    end

    always_ff @(posedge i_sclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_avg_data <= '0;
        end else if (w_load) begin
            r_avg_data <= w_result;
        end
    end

    // A drop in the same cycle as a clear request keeps the flag set.
    always_ff @(posedge i_sclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_overrun <= 1'b0;
        end else if (w_drop) begin
            r_overrun <= 1'b1;
        end else if (i_overrun_clr) begin
            r_overrun <= 1'b0;
        end
    end

    assign o_avg_data  = r_avg_data;
    assign o_avg_valid = (r_state == ST_FULL);
    assign o_overrun   = r_overrun;

endmodule

// File: tb/tb_adc_sample_averager.sv
// Scoreboard bench for adc_sample_averager: directed plan plus random traffic,
// checked against a queue-based block-mean model.
module tb_adc_sample_averager;

    localparam int DW = 16;
    localparam int L2 = 3;
    localparam int NS = 1 << L2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en, sv, rdy, clr;
    logic [DW-1:0] sd;
    logic [DW-1:0] o_avg_data;
    logic          o_avg_valid;
    logic          o_overrun;
    logic [L2:0]   o_sample_cnt;

    int   n_checks = 0;
    int   n_fail   = 0;
    bit   mon_en   = 0;

    int   blk[$];
    int   exp_q[$];
    bit   m_full = 0;
    bit   m_ovr  = 0;
    int   m_data = 0;

    always #5 clk = ~clk;

    adc_sample_averager #(.DATA_W(DW), .LOG2_N(L2)) dut (
        .i_sclk         (clk),
        .i_rst_n        (rst_n),
        .i_enable       (en),
        .i_sample_data  (sd),
        .i_sample_valid (sv),
        .o_avg_data     (o_avg_data),
        .o_avg_valid    (o_avg_valid),
        .i_avg_ready    (rdy),
        .o_overrun      (o_overrun),
        .i_overrun_clr  (clr),
        .o_sample_cnt   (o_sample_cnt)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int block_mean();
        longint s = 0;
        foreach (blk[i]) s += blk[i];
        return (NS == 1) ? int'(s) : int'((s + NS / 2) / NS);
    endfunction

    // Reference behaviour for one clock edge, using the inputs applied for that edge.
    task automatic model_edge();
        bit xfer = m_full && rdy;
        bit load = 0;
        bit drop = 0;
        int avg;
        if (!en) begin
            blk.delete();
        end else if (sv) begin
            blk.push_back(int'(sd));
            if (blk.size() == NS) begin
                avg = block_mean();
                blk.delete();
                if (!m_full || rdy) begin
                    load   = 1;
                    m_data = avg;
                    exp_q.push_back(avg);
                end else begin
                    drop = 1;
                end
            end
        end
        if (load) m_full = 1;
        else if (xfer) m_full = 0;
        if (drop) m_ovr = 1;
        else if (clr) m_ovr = 0;
    endtask

    task automatic cyc(input bit e, input bit v, input int d, input bit r, input bit c);
        en = e; sv = v; sd = DW'(d); rdy = r; clr = c;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic samples(input int n, input int d, input bit r);
        repeat (n) cyc(1, 1, d, r, 0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_data"},  o_avg_data,   0);
        chk({tag, "_valid"}, o_avg_valid,  0);
        chk({tag, "_ovr"},   o_overrun,    0);
        chk({tag, "_cnt"},   o_sample_cnt, 0);
    endtask

    // Monitor: per-cycle status against the model, pop and compare on every transfer.
    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            chk("valid", o_avg_valid, m_full);
            chk("overrun", o_overrun, m_ovr);
            chk("sample_cnt", o_sample_cnt, blk.size());
            if (m_full) chk("held_data", o_avg_data, m_data);
            if (o_avg_valid && rdy) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_transfer: got data %0d with empty scoreboard", o_avg_data);
                end else begin
                    chk("xfer_data", o_avg_data, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d checks, %0d failures", n_checks, n_fail);
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; en = 0; sv = 0; sd = '0; rdy = 0; clr = 0;
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        rst_n  = 1'b1;
        mon_en = 1;

        // Ramp 100..107 -> 828/8 = 103.5 -> 104, valid one cycle after the 8th strobe.
        for (int i = 0; i < 7; i++) cyc(1, 1, 100 + i, 1, 0);
        chk("ramp_not_early", o_avg_valid, 0);
        cyc(1, 1, 107, 1, 0);
        chk("ramp_valid", o_avg_valid, 1);
        chk("ramp_data", o_avg_data, 104);
        cyc(1, 0, 0, 1, 0);

        // Full scale and rounding tie.
        samples(8, 16'hFFFF, 1);
        chk("fullscale", o_avg_data, 16'hFFFF);
        cyc(1, 0, 0, 1, 0);
        samples(7, 0, 1);
        cyc(1, 1, 4, 1, 0);
        chk("tie_round", o_avg_data, 1);
        cyc(1, 0, 0, 1, 0);

        // Backpressure: four blocks while stalled.
        samples(16, 50, 0);
        chk("bp_ovr_2nd", o_overrun, 1);
        samples(16, 60, 0);
        chk("bp_held", o_avg_data, 50);
        cyc(1, 0, 0, 1, 0);
        chk("bp_drained", o_avg_valid, 0);
        cyc(1, 0, 0, 0, 1);
        chk("bp_clr", o_overrun, 0);
        samples(8, 70, 0);
        samples(7, 80, 0);
        cyc(1, 1, 80, 0, 1);
        chk("clr_vs_drop", o_overrun, 1);
        chk("clr_vs_drop_data", o_avg_data, 70);
        cyc(1, 0, 0, 1, 1);
        chk("drain_clr_ovr", o_overrun, 0);

        // Transfer and completion on the same edge.
        samples(8, 10, 0);
        samples(7, 20, 0);
        cyc(1, 1, 20, 1, 0);
        chk("simul_valid", o_avg_valid, 1);
        chk("simul_data", o_avg_data, 20);
        chk("simul_ovr", o_overrun, 0);
        cyc(1, 0, 0, 1, 0);

        // Asynchronous reset mid-block.
        samples(5, 1000, 1);
        sv = 0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_zero("async_rst");
        blk.delete(); exp_q.delete(); m_full = 0; m_ovr = 0; m_data = 0;
        #1 rst_n = 1'b1;
        @(posedge clk);
        model_edge();
        #1;
        samples(8, 7, 1);
        chk("post_rst_avg", o_avg_data, 7);
        cyc(1, 0, 0, 1, 0);

        // Enable drop discards a partial block; strobes while disabled are ignored.
        samples(3, 500, 1);
        cyc(0, 1, 999, 1, 0);
        cyc(0, 1, 999, 1, 0);
        chk("en_drop_cnt", o_sample_cnt, 0);
        samples(8, 9, 1);
        chk("en_drop_avg", o_avg_data, 9);
        cyc(1, 0, 0, 1, 0);

        // Random traffic.
        for (int i = 0; i < 2000; i++) begin
            int d;
            case ($urandom_range(0, 7))
                0:       d = 0;
                1:       d = 16'hFFFF;
                default: d = int'($urandom_range(0, 16'hFFFF));
            endcase
            cyc(($urandom_range(0, 15) != 0), $urandom_range(0, 1) == 1, d,
                ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0));
        end

        repeat (3) cyc(1, 0, 0, 1, 0);
        chk("scoreboard_empty", exp_q.size(), 0);
        mon_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
